// File: rtl/instr_encoder.sv
// Streaming LEGv8 encoder: symbolic op in, 32-bit machine word plus byte address out via a 2-entry FIFO.
// Optional immediate range checking is compiled in with `define INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [18:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] addr,
  output logic              err,
  input  logic              err_clr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_FULL  = 2'd2;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  function automatic logic [31:0] encode(input logic [3:0] f_op, input logic [4:0] f_rd,
                                         input logic [4:0] f_rn, input logic [4:0] f_rm,
                                         input logic [18:0] f_imm);
    logic [31:0] w;
    w = 32'd0;
    case (f_op)
      4'd0: w = {11'b10001011000, f_rm, 6'b000000, f_rn, f_rd};
      4'd1: w = {11'b11001011000, f_rm, 6'b000000, f_rn, f_rd};
      4'd2: w = {11'b10001010000, f_rm, 6'b000000, f_rn, f_rd};
      4'd3: w = {11'b10101010000, f_rm, 6'b000000, f_rn, f_rd};
      4'd4: w = {10'b1001000100, f_imm[11:0], f_rn, f_rd};
      4'd5: w = {11'b11111000010, f_imm[8:0], 2'b00, f_rn, f_rd};
      4'd6: w = {11'b11111000000, f_imm[8:0], 2'b00, f_rn, f_rd};
      4'd7: w = {8'b10110100, f_imm, f_rd};
      4'd8: w = {8'b10110101, f_imm, f_rd};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  // ADDI takes an unsigned 12-bit immediate; D-type offsets are signed 9-bit.
  function automatic logic range_ok(input logic [3:0] f_op, input logic [18:0] f_imm);
    logic ok;
    ok = 1'b1;
    case (f_op)
      4'd4:       ok = (f_imm[18:12] == 7'd0);
      4'd5, 4'd6: ok = (&f_imm[18:8]) | ~(|f_imm[18:8]);
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction
`endif

  logic [1:0]        r_state;
  logic [31:0]       r_head_instr;
  logic [ADDR_W-1:0] r_head_addr;
  logic [31:0]       r_tail_instr;
  logic [ADDR_W-1:0] r_tail_addr;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;

  logic        w_imm_ok;
  logic        w_ok;
  logic        w_accept;
  logic        w_enq;
  logic        w_drop;
  logic        w_pop;
  logic [31:0] w_word;

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  assign w_imm_ok = range_ok(op, imm);
`else
  assign w_imm_ok = 1'b1;
`endif

  assign w_ok     = (op <= 4'd8) & w_imm_ok;
  assign w_accept = in_valid & in_ready;
  assign w_enq    = w_accept & w_ok;
  assign w_drop   = w_accept & ~w_ok;
  assign w_pop    = out_valid & out_ready;
  assign w_word   = encode(op, rd, rn, rm, imm);

  assign in_ready  = (r_state != S_FULL);
  assign out_valid = (r_state != S_EMPTY);
  assign instr     = r_head_instr;
  assign addr      = r_head_addr;
  assign err       = r_err;

  // Head slot drives the outputs directly; tail only holds the second word under backpressure.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_EMPTY;
      r_head_instr <= 32'd0;
      r_head_addr  <= BASE_ADDR;
      r_tail_instr <= 32'd0;
      r_tail_addr  <= BASE_ADDR;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_enq) begin
            r_head_instr <= w_word;
            r_head_addr  <= r_addr;
            r_state      <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_enq && w_pop) begin
            r_head_instr <= w_word;
            r_head_addr  <= r_addr;
          end else if (w_enq) begin
            r_tail_instr <= w_word;
            r_tail_addr  <= r_addr;
            r_state      <= S_FULL;
          end else if (w_pop) begin
            r_state <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_pop) begin
            r_head_instr <= r_tail_instr;
            r_head_addr  <= r_tail_addr;
            r_state      <= S_ONE;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= BASE_ADDR;
      r_err  <= 1'b0;
    end else begin
      if (w_enq) r_addr <= r_addr + ADDR_STEP;
      if (w_drop) r_err <= 1'b1;
      else if (err_clr) r_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Testbench for instr_encoder: directed scenarios plus randomized traffic against a queue-based model.
module tb_instr_encoder;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [18:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [63:0] addr;
  logic        err;
  logic        err_clr;

  logic        w_in_ready;
  logic        w_out_valid;
  logic [31:0] w_instr;
  logic [3:0]  w_addr;
  logic        w_err;

  instr_encoder dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .instr(instr), .addr(addr),
    .err(err), .err_clr(err_clr)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(4'd12)) dut_w (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(w_in_ready),
    .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .out_valid(w_out_valid), .out_ready(out_ready), .instr(w_instr), .addr(w_addr),
    .err(w_err), .err_clr(err_clr)
  );

  typedef struct {
    logic [31:0] w;
    logic [63:0] a;
  } ent_t;

  ent_t        expq[$];
  logic [63:0] maddr;
  logic        merr;
  bit          last_acc;
  int          n_chk;
  int          n_pass;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference encoding computed from field weights rather than bit concatenation.
  function automatic logic [31:0] model_word(input int o, input int d, input int n, input int m,
                                             input int unsigned im);
    longint unsigned r;
    r = 0;
    case (o)
      0: r = 64'h458 * 2097152 + m * 65536 + n * 32 + d;
      1: r = 64'h658 * 2097152 + m * 65536 + n * 32 + d;
      2: r = 64'h450 * 2097152 + m * 65536 + n * 32 + d;
      3: r = 64'h550 * 2097152 + m * 65536 + n * 32 + d;
      4: r = 64'h91000000 + (im % 4096) * 1024 + n * 32 + d;
      5: r = 64'hF8400000 + (im % 512) * 4096 + n * 32 + d;
      6: r = 64'hF8000000 + (im % 512) * 4096 + n * 32 + d;
      7: r = 64'hB4000000 + im * 32 + d;
      8: r = 64'hB5000000 + im * 32 + d;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  function automatic bit model_ok(input int o, input int unsigned im);
    if (o > 8) return 0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    if (o == 4 && im >= 4096) return 0;
    if ((o == 5 || o == 6) && !(im < 256 || im >= 524288 - 256)) return 0;
`endif
    return 1;
  endfunction

  task automatic tick();
    bit   acc;
    bit   pop;
    bit   ok;
    ent_t e;
    acc = in_valid && (expq.size() < 2);
    pop = (expq.size() > 0) && out_ready;
    ok  = model_ok(int'(op), int'(imm));
    last_acc = acc;
    if (pop) void'(expq.pop_front());
    if (acc && ok) begin
      e.w = model_word(int'(op), int'(rd), int'(rn), int'(rm), int'(imm));
      e.a = maddr;
      expq.push_back(e);
      maddr = maddr + 4;
    end
    if (acc && !ok) merr = 1'b1;
    else if (err_clr) merr = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(input int o, input int d, input int n, input int m, input int im);
    op  = 4'(o);
    rd  = 5'(d);
    rn  = 5'(n);
    rm  = 5'(m);
    imm = 19'(im);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    set_op(0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    expq.delete();
    maddr = 64'd0;
    merr  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else n_pass++;
    n_chk++; if (instr !== 32'd0) $display("FAIL reset_instr got=%h exp=0", instr); else n_pass++;
    n_chk++; if (addr !== 64'd0) $display("FAIL reset_addr got=%h exp=0", addr); else n_pass++;
    n_chk++; if (err !== 1'b0) $display("FAIL reset_err got=%0b exp=0", err); else n_pass++;
    n_chk++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else n_pass++;
    n_chk++; if (w_addr !== 4'd12) $display("FAIL reset_base_addr got=%0d exp=12", w_addr); else n_pass++;
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(0, 3, 1, 2, 0);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1) $display("FAIL add_valid got=%0b exp=1", out_valid); else n_pass++;
    n_chk++; if (instr !== 32'h8B020023) $display("FAIL add_instr got=%h exp=8b020023", instr); else n_pass++;
    n_chk++; if (addr !== 64'd0) $display("FAIL add_addr got=%0d exp=0", addr); else n_pass++;
    tick();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL add_drained got=%0b exp=0", out_valid); else n_pass++;
  endtask

  task automatic test_sequence();
    logic [31:0] ew[3];
    ew[0] = 32'h91001401; ew[1] = 32'hF85F8022; ew[2] = 32'hB4FFFFC4;
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      case (i)
        0: set_op(4, 1, 0, 0, 5);
        1: set_op(5, 2, 1, 0, -8);
        default: set_op(7, 4, 0, 0, -2);
      endcase
      tick();
      n_chk++;
      if (out_valid !== 1'b1 || instr !== ew[i] || addr !== 64'(i * 4))
        $display("FAIL seq_word%0d got v=%0b %h @%0d exp v=1 %h @%0d", i, out_valid, instr, addr, ew[i], i * 4);
      else n_pass++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    int got;
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_op(1, 5, 6, 7, 0);
    tick();
    set_op(4, 8, 9, 0, 100);
    tick();
    set_op(8, 10, 0, 0, 1234);
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b exp=0", in_ready); else n_pass++;
    tick();
    n_chk++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_hold got=%0b exp=0", in_ready); else n_pass++;
    n_chk++;
    if (addr !== 64'd0 || instr !== expq[0].w) $display("FAIL bp_stable got=%h @%0d exp=%h @0", instr, addr, expq[0].w);
    else n_pass++;
    out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && got < 3; c++) begin
      if (out_valid === 1'b1) begin
        n_chk++;
        if (addr !== 64'(got * 4) || instr !== expq[0].w)
          $display("FAIL bp_drain%0d got=%h @%0d exp=%h @%0d", got, instr, addr, expq[0].w, got * 4);
        else n_pass++;
        got++;
      end
      tick();
      if (last_acc) in_valid = 1'b0;
    end
    n_chk++; if (got != 3) $display("FAIL bp_drain_count got=%0d exp=3", got); else n_pass++;
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(12, 1, 2, 3, 0);
    tick();
    n_chk++; if (err !== 1'b1) $display("FAIL ill_err got=%0b exp=1", err); else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL ill_dropped got=%0b exp=0", out_valid); else n_pass++;
    set_op(1, 0, 0, 0, 0);
    tick();
    in_valid = 1'b0;
    n_chk++;
    if (instr !== 32'hCB000000 || addr !== 64'd0 || out_valid !== 1'b1)
      $display("FAIL ill_sub got=%h @%0d v=%0b exp=cb000000 @0 v=1", instr, addr, out_valid);
    else n_pass++;
    n_chk++; if (err !== 1'b1) $display("FAIL ill_sticky got=%0b exp=1", err); else n_pass++;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_chk++; if (err !== 1'b0) $display("FAIL ill_clr got=%0b exp=0", err); else n_pass++;
    err_clr  = 1'b1;
    in_valid = 1'b1;
    set_op(13, 0, 0, 0, 0);
    tick();
    err_clr  = 1'b0;
    in_valid = 1'b0;
    n_chk++; if (err !== 1'b1) $display("FAIL ill_set_wins got=%0b exp=1", err); else n_pass++;
  endtask

  task automatic test_range();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(4, 0, 0, 0, 4096);
    tick();
    in_valid = 1'b0;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    n_chk++; if (err !== 1'b1 || out_valid !== 1'b0) $display("FAIL range_drop got err=%0b v=%0b exp err=1 v=0", err, out_valid); else n_pass++;
`else
    n_chk++;
    if (err !== 1'b0 || out_valid !== 1'b1 || instr !== 32'h91000000)
      $display("FAIL range_trunc got err=%0b v=%0b %h exp err=0 v=1 91000000", err, out_valid, instr);
    else n_pass++;
`endif
    tick();
  endtask

  task automatic test_random();
    int o;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      err_clr   = ($urandom_range(0, 15) == 0);
      o = ($urandom_range(0, 9) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
      set_op(o, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 300)) : int'($urandom_range(0, 524287)));
      tick();
      n_chk++;
      if (out_valid !== (expq.size() > 0) || in_ready !== (expq.size() < 2) || err !== merr)
        $display("FAIL rand_ctl%0d got v=%0b r=%0b e=%0b exp v=%0b r=%0b e=%0b", c, out_valid, in_ready, err,
                 expq.size() > 0, expq.size() < 2, merr);
      else n_pass++;
      if (expq.size() > 0) begin
        n_chk++;
        if (instr !== expq[0].w || addr !== expq[0].a)
          $display("FAIL rand_word%0d got=%h @%0d exp=%h @%0d", c, instr, addr, expq[0].w, expq[0].a);
        else n_pass++;
      end
    end
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  task automatic test_wrap_and_async_reset();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    set_op(2, 1, 2, 3, 0);
    tick();
    n_chk++; if (w_out_valid !== 1'b1 || w_addr !== 4'd12) $display("FAIL wrap_first got v=%0b @%0d exp v=1 @12", w_out_valid, w_addr); else n_pass++;
    set_op(3, 4, 5, 6, 0);
    tick();
    in_valid = 1'b0;
    n_chk++; if (w_out_valid !== 1'b1 || w_addr !== 4'd0) $display("FAIL wrap_second got v=%0b @%0d exp v=1 @0", w_out_valid, w_addr); else n_pass++;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_op(0, 7, 7, 7, 0);
    tick();
    in_valid = 1'b0;
    n_chk++; if (out_valid !== 1'b1 || w_out_valid !== 1'b1) $display("FAIL areset_pre got v=%0b/%0b exp 1/1", out_valid, w_out_valid); else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (out_valid !== 1'b0 || w_out_valid !== 1'b0 || instr !== 32'd0 || addr !== 64'd0 || w_addr !== 4'd12)
      $display("FAIL areset_now got v=%0b/%0b %h @%0d/%0d exp v=0/0 0 @0/12", out_valid, w_out_valid, instr, addr, w_addr);
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    expq.delete();
    maddr = 64'd0;
    merr  = 1'b0;
  endtask

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    maddr     = 64'd0;
    merr      = 1'b0;
    last_acc  = 1'b0;
    set_op(0, 0, 0, 0, 0);
    test_reset();
    test_add();
    test_sequence();
    test_backpressure();
    test_illegal();
    test_range();
    test_random();
    test_wrap_and_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
